jpeg_bitstream_packer: RTL and testbench

- Downstream of the Huffman encoder controller. Accepts variable-length Huffman code words (MSB-first, up to 16 bits) and packs them into an MSB-first byte stream.
- Inserts a 0x00 stuff byte after every 0xFF data byte.
- On flush, pads the last partial byte with 1s.
- Presents bytes on a valid/ready interface to the file writer or DMA.

---
 rtl/jpeg_pkg.sv | 21 ++
 rtl/jpeg_byte_fifo.sv | 53 +++++
 rtl/jpeg_bitstream_packer.sv | 174 +++++++++++++++++
 tb/tb_jpeg_bitstream_packer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG bitstream packer.
// The MARKER_* states exist only when JPEG_PACKER_EOI_MARKER_EN is defined.
package jpeg_pkg;

  localparam int         MAX_CODE_LEN       = 16;
  localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_EOI_CODE      = 8'hD9;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    PAD       = 3'd1,
    DRAIN     = 3'd2,
`ifdef JPEG_PACKER_EOI_MARKER_EN
    MARKER_FF = 3'd3,
    MARKER_D9 = 3'd4,
`endif
    WAIT      = 3'd5
  } state_t;

endpackage

// File: rtl/jpeg_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
// When empty, head keeps showing the most recently popped byte.
module jpeg_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  last;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? last : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last   <= 8'h00;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        last   <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jpeg_bitstream_packer.sv
// Packs MSB-first Huffman code words into a byte stream with 0xFF/0x00 stuffing and 1-padding on flush.
// Define JPEG_PACKER_EOI_MARKER_EN to append an FF D9 end-of-image marker after each flush.
module jpeg_bitstream_packer #(
  parameter int ACC_WIDTH    = 32,
  parameter int MAX_CODE_LEN = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [4:0]  in_len,
  input  logic        flush,
  output logic        flush_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [31:0] byte_count
);

  import jpeg_pkg::*;

  localparam int CW = $clog2(ACC_WIDTH + 1);

  state_t              state;
  state_t              state_next;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [ACC_WIDTH-1:0] base_acc;
  logic [ACC_WIDTH-1:0] pad_mask;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_next;
  logic [CW-1:0]       base_cnt;
  logic [CW-1:0]       padded;
  logic [CW-1:0]       shamt;
  logic                stuff_pending;
  logic                stuff_next;
  logic [4:0]          len_eff;
  logic [15:0]         code_masked;
  logic                accept;
  logic                push_ok;
  logic                extract;
  logic                push;
  logic [7:0]          push_data;
  logic                fifo_full;
  logic                fifo_empty;

  assign len_eff     = (in_len > 5'(MAX_CODE_LEN)) ? 5'(MAX_CODE_LEN) : in_len;
  assign code_masked = in_data & ~(16'hFFFF << len_eff);
  assign in_ready    = !reset && (state == RUN) && (count <= CW'(ACC_WIDTH - MAX_CODE_LEN));
  assign accept      = in_valid && in_ready;
  assign push_ok     = ((state == RUN) || (state == DRAIN)) && !fifo_full;
  assign extract     = push_ok && !stuff_pending && (count >= CW'(8));
  assign padded      = (count + CW'(7)) & ~CW'(7);
  assign pad_mask    = ({ACC_WIDTH{1'b1}} >> count) & ~({ACC_WIDTH{1'b1}} >> padded);
  assign out_valid   = !fifo_empty;

  // Byte extraction, stuffing, code insertion and flush sequencing.
  always_comb begin
    state_next = state;
    stuff_next = stuff_pending;
    push       = 1'b0;
    push_data  = acc[ACC_WIDTH-1 -: 8];
    base_acc   = acc;
    base_cnt   = count;
    if (extract) begin
      push       = 1'b1;
      base_acc   = acc << 8;
      base_cnt   = count - CW'(8);
      stuff_next = (acc[ACC_WIDTH-1 -: 8] == 8'hFF);
    end else if (push_ok && stuff_pending) begin
      push       = 1'b1;
      push_data  = JPEG_STUFF_BYTE;
      stuff_next = 1'b0;
    end else begin
      push = 1'b0;
    end
    // New bits land right after the bits still held once this cycle's byte leaves.
    shamt      = CW'(ACC_WIDTH) - base_cnt - CW'(len_eff);
    acc_next   = base_acc;
    count_next = base_cnt;
    if (accept) begin
      acc_next   = base_acc | (ACC_WIDTH'(code_masked) << shamt);
      count_next = base_cnt + CW'(len_eff);
    end else begin
      acc_next = base_acc;
    end
    case (state)
      RUN: begin
        if (flush) state_next = PAD;
        else       state_next = RUN;
      end
      PAD: begin
        acc_next   = acc | pad_mask;
        count_next = padded;
        state_next = DRAIN;
      end
      DRAIN: begin
        if ((count == CW'(0)) && !stuff_pending) begin
`ifdef JPEG_PACKER_EOI_MARKER_EN
          state_next = MARKER_FF;
`else
          state_next = WAIT;
`endif
        end else begin
          state_next = DRAIN;
        end
      end
`ifdef JPEG_PACKER_EOI_MARKER_EN
      MARKER_FF: begin
        if (!fifo_full) begin
          push       = 1'b1;
          push_data  = JPEG_MARKER_PREFIX;
          state_next = MARKER_D9;
        end else begin
          state_next = MARKER_FF;
        end
      end
      MARKER_D9: begin
        if (!fifo_full) begin
          push       = 1'b1;
          push_data  = JPEG_EOI_CODE;
          state_next = WAIT;
        end else begin
          state_next = MARKER_D9;
        end
      end
`endif
      WAIT: begin
        acc_next   = '0;
        count_next = '0;
        if (fifo_empty) state_next = RUN;
        else            state_next = WAIT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State, accumulator and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      acc           <= '0;
      count         <= '0;
      stuff_pending <= 1'b0;
      flush_done    <= 1'b0;
      byte_count    <= 32'd0;
    end else begin
      state         <= state_next;
      acc           <= acc_next;
      count         <= count_next;
      stuff_pending <= stuff_next;
      flush_done    <= (state == WAIT) && fifo_empty;
      byte_count    <= byte_count + {31'd0, push};
    end
  end

  jpeg_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Self-checking bench for jpeg_bitstream_packer: a bit-queue reference model builds the expected byte stream.
module tb_jpeg_bitstream_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_len;
  logic        flush;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [31:0] byte_count;

  int vectors = 0;
  int miscompares = 0;
  int fd_count = 0;
  int exp_total = 0;
  bit mbits[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  always #5 clock = ~clock;

  jpeg_bitstream_packer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_len     (in_len),
    .flush      (flush),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .byte_count (byte_count)
  );

  // Record every byte handed over and every flush_done cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) rx_q.push_back(out_data);
      if (flush_done) fd_count++;
    end
  end

  function automatic void model_emit();
    logic [7:0] b;
    while (mbits.size() >= 8) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], mbits.pop_front()};
      exp_q.push_back(b);
      exp_total++;
      if (b == 8'hFF) begin
        exp_q.push_back(8'h00);
        exp_total++;
      end
    end
  endfunction

  function automatic void model_code(input logic [15:0] d, input int len);
    int l;
    l = (len > 16) ? 16 : len;
    for (int i = l - 1; i >= 0; i--) mbits.push_back(d[i]);
    model_emit();
  endfunction

  function automatic void model_flush();
    while ((mbits.size() % 8) != 0) mbits.push_back(1'b1);
    model_emit();
`ifdef JPEG_PACKER_EOI_MARKER_EN
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    exp_total += 2;
`endif
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [4:0] l, input logic with_flush);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data = d;
    in_len = l;
    @(negedge clock);
    while (!in_ready && waited < 300) begin
      waited++;
      @(negedge clock);
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end else begin
      flush = with_flush;
      model_code(d, int'(l));
      if (with_flush) model_flush();
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_flush_done(input int expected);
    int waited;
    waited = 0;
    while (fd_count < expected && waited < 2000) begin
      waited++;
      @(negedge clock);
    end
    repeat (6) @(negedge clock);
    vectors++;
    if (fd_count !== expected) begin
      miscompares++;
      $display("FAIL flush_done_pulses: got %0d, required %0d", fd_count, expected);
    end
  endtask

  task automatic check_stream(input string name);
    int waited;
    waited = 0;
    while (rx_q.size() < exp_q.size() && waited < 3000) begin
      waited++;
      @(negedge clock);
    end
    repeat (8) @(negedge clock);
    vectors++;
    if (rx_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_len: got %0d bytes, required %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      vectors++;
      if (rx_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, rx_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (byte_count !== 32'(exp_total)) begin
      miscompares++;
      $display("FAIL %s_byte_count: got %0d, required %0d", name, byte_count, exp_total);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0000;
    in_len = 5'd0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready_during: got %b, required 0", in_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({out_valid, flush_done, in_ready} !== 3'b001 || out_data !== 8'h00 || byte_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b done=%b ready=%b data=%02h count=%0d, required 0 0 1 00 0",
               out_valid, flush_done, in_ready, out_data, byte_count);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_nibbles();
    send(16'h000A, 5'd4, 1'b0);
    send(16'h000C, 5'd4, 1'b0);
    check_stream("nibbles");
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL nibbles_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_stuffing();
    send(16'hFF00, 5'd16, 1'b0);
    check_stream("stuffing");
    @(posedge clock);
    #1;
  endtask

  task automatic test_flush();
    fd_count = 0;
    send(16'h0005, 5'd3, 1'b1);
    wait_flush_done(1);
    check_stream("flush");
    @(posedge clock);
    #1;
  endtask

  task automatic test_len_edge();
    send(16'hFFFF, 5'd0, 1'b0);
    repeat (5) @(negedge clock);
    vectors++;
    if (rx_q.size() != 0) begin
      miscompares++;
      $display("FAIL len0_no_bytes: got %0d bytes, required 0", rx_q.size());
    end
    @(posedge clock);
    #1;
    send(16'hABCD, 5'd20, 1'b0);
    send(16'hFFF3, 5'd2, 1'b0);
    send(16'hFF3F, 5'd6, 1'b0);
    check_stream("len_edge");
    @(posedge clock);
    #1;
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h1234;
    in_len = 5'd16;
    repeat (30) begin
      @(negedge clock);
      if (in_ready) begin
        accepted++;
        model_code(16'h1234, 16);
      end
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if (accepted != 4) begin
      miscompares++;
      $display("FAIL bp_accepted: got %0d codes, required 4", accepted);
    end
    vectors++;
    if ({in_ready, out_valid} !== 2'b01 || out_data !== 8'h12) begin
      miscompares++;
      $display("FAIL bp_stalled: ready=%b valid=%b data=%02h, required 0 1 12", in_ready, out_valid, out_data);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    check_stream("backpressure");
    @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    bit done;
    int flushes;
    bit f;
    done = 1'b0;
    flushes = 0;
    fd_count = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          f = ($urandom_range(0, 9) == 0);
          if (f) flushes++;
          send(16'($urandom_range(0, 65535)), 5'($urandom_range(0, 20)), f);
        end
        send(16'h0000, 5'd0, 1'b1);
        flushes++;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_flush_done(flushes);
    check_stream("random");
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_in_drain();
    out_ready = 1'b0;
    send(16'h1234, 5'd16, 1'b0);
    send(16'h1234, 5'd16, 1'b0);
    send(16'h1234, 5'd16, 1'b0);
    send(16'h1234, 5'd16, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    mbits.delete();
    exp_q.delete();
    rx_q.delete();
    exp_total = 0;
    fd_count = 0;
    @(negedge clock);
    vectors++;
    if ({out_valid, in_ready} !== 2'b01 || byte_count !== 32'd0) begin
      miscompares++;
      $display("FAIL drain_reset: valid=%b ready=%b count=%0d, required 0 1 0", out_valid, in_ready, byte_count);
    end
    repeat (10) @(negedge clock);
    vectors++;
    if (fd_count != 0 || rx_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_reset_quiet: flush_done=%0d bytes=%0d, required 0 0", fd_count, rx_q.size());
    end
    @(posedge clock);
    #1;
    send(16'h00A5, 5'd8, 1'b0);
    check_stream("after_reset");
  endtask

  initial begin
    test_reset();
    test_nibbles();
    test_stuffing();
    test_flush();
    test_len_edge();
    test_backpressure();
    test_random();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
